// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: address/data word types,
// the FSM state encoding and a small port-decode helper.
package mem_port_arbiter_pkg;

   localparam int ADDR_W  = 32;
   localparam int WORD_W  = 32;
   localparam int TAG_W   = 32;
   localparam int N_PORTS = 2;

   typedef logic [ADDR_W-1:0] Address;
   typedef logic [WORD_W-1:0] MemoryWord;
   typedef logic [TAG_W-1:0]  tag_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // One-hot done vector for a single load port id.
   function automatic logic [N_PORTS-1:0] port_onehot(input logic port);
      logic [N_PORTS-1:0] v;
      if (port) begin
         v = 2'b10;
      end else begin
         v = 2'b01;
      end
      return v;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection: load eligibility (address ordering
// against a pending store), store-vs-load priority with starvation
// override, and round-robin between the two load ports.
module mem_port_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] i_ld_req,
   input  Address     i_ld_addr0,
   input  Address     i_ld_addr1,
   input  logic       i_st_req,
   input  Address     i_st_addr,
   input  logic       i_starved,
   input  logic       i_rr_pri,
   output logic       o_valid,
   output logic       o_is_store,
   output logic       o_port
);

   logic [1:0] w_elig;
   logic       w_any_ld;

   // A load that hits the pending store's address must wait for the store.
   always_comb begin
      w_elig[0] = i_ld_req[0] & ~(i_st_req & (i_ld_addr0 == i_st_addr));
      w_elig[1] = i_ld_req[1] & ~(i_st_req & (i_ld_addr1 == i_st_addr));
      w_any_ld  = |w_elig;
   end

   // Store wins when starved or when no load can go; otherwise loads, with round-robin on a tie.
   always_comb begin
      o_valid    = 1'b0;
      o_is_store = 1'b0;
      o_port     = 1'b0;
      if (i_st_req && (i_starved || !w_any_ld)) begin
         o_valid    = 1'b1;
         o_is_store = 1'b1;
      end else if (w_any_ld) begin
         o_valid = 1'b1;
         if (w_elig == 2'b11) begin
            o_port = i_rr_pri;
         end else begin
            o_port = w_elig[1];
         end
      end else begin
         o_valid = 1'b0;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-load-port plus one-store-port arbiter in front of a single cache
// port. IDLE picks a winner and latches its payload, BUSY holds the
// cache request until mem_ready, RESP pulses the completion for one cycle.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [1:0] i_ld_req,
   input  Address     i_ld_addr0,
   input  Address     i_ld_addr1,
   input  tag_t       i_ld_tag0,
   input  tag_t       i_ld_tag1,
   input  logic       i_st_req,
   input  Address     i_st_addr,
   input  MemoryWord  i_st_data,
   output logic [1:0] o_ld_done,
   output MemoryWord  o_ld_data,
   output tag_t       o_ld_done_tag,
   output logic       o_st_ack,
   output logic       o_mem_req,
   output logic       o_mem_we,
   output Address     o_mem_addr,
   output MemoryWord  o_mem_wdata,
   input  logic       i_mem_ready,
   input  MemoryWord  i_mem_rdata,
   output logic       o_busy
);

   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           r_state;
   logic [CNT_W-1:0] r_starve;
   logic             r_rr_pri;
   logic             r_port;
   logic             r_is_store;
   tag_t             r_tag;

   logic [1:0]       r_ld_done;
   MemoryWord        r_ld_data;
   tag_t             r_ld_done_tag;
   logic             r_st_ack;
   logic             r_mem_req;
   logic             r_mem_we;
   Address           r_mem_addr;
   MemoryWord        r_mem_wdata;

   logic             w_valid;
   logic             w_is_store;
   logic             w_port;
   logic             w_starved;

   // Starvation override is active once the counter has saturated.
   always_comb begin
      w_starved = (r_starve == CNT_MAX);
   end

   mem_port_pick u_pick (
      .i_ld_req   (i_ld_req),
      .i_ld_addr0 (i_ld_addr0),
      .i_ld_addr1 (i_ld_addr1),
      .i_st_req   (i_st_req),
      .i_st_addr  (i_st_addr),
      .i_starved  (w_starved),
      .i_rr_pri   (r_rr_pri),
      .o_valid    (w_valid),
      .o_is_store (w_is_store),
      .o_port     (w_port)
   );

   // Arbitration FSM: grant/latch in IDLE, hold request in BUSY, pulse completion in RESP.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= ST_IDLE;
         r_starve      <= CNT_ZERO;
         r_rr_pri      <= 1'b0;
         r_port        <= 1'b0;
         r_is_store    <= 1'b0;
         r_tag         <= {TAG_W{1'b0}};
         r_ld_done     <= 2'b00;
         r_ld_data     <= {WORD_W{1'b0}};
         r_ld_done_tag <= {TAG_W{1'b0}};
         r_st_ack      <= 1'b0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= {ADDR_W{1'b0}};
         r_mem_wdata   <= {WORD_W{1'b0}};
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Starve count only advances on load grants that bypass a waiting store.
               if (!i_st_req) begin
                  r_starve <= CNT_ZERO;
               end else if (w_valid && w_is_store) begin
                  r_starve <= CNT_ZERO;
               end else if (w_valid && (r_starve != CNT_MAX)) begin
                  r_starve <= r_starve + CNT_ONE;
               end else begin
                  r_starve <= r_starve;
               end

               if (w_valid) begin
                  r_state    <= ST_BUSY;
                  r_mem_req  <= 1'b1;
                  r_is_store <= w_is_store;
                  r_port     <= w_port;
                  if (w_is_store) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= i_st_addr;
                     r_mem_wdata <= i_st_data;
                     r_tag       <= {TAG_W{1'b0}};
                  end else begin
                     r_mem_we    <= 1'b0;
                     r_mem_addr  <= w_port ? i_ld_addr1 : i_ld_addr0;
                     r_mem_wdata <= {WORD_W{1'b0}};
                     r_tag       <= w_port ? i_ld_tag1 : i_ld_tag0;
                     r_rr_pri    <= ~w_port;
                  end
               end else begin
                  r_state <= ST_IDLE;
               end
            end

            ST_BUSY: begin
               if (i_mem_ready) begin
                  r_state     <= ST_RESP;
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= {ADDR_W{1'b0}};
                  r_mem_wdata <= {WORD_W{1'b0}};
                  if (r_is_store) begin
                     r_st_ack <= 1'b1;
                  end else begin
                     r_ld_done     <= port_onehot(r_port);
                     r_ld_data     <= i_mem_rdata;
                     r_ld_done_tag <= r_tag;
                  end
               end else begin
                  r_state <= ST_BUSY;
               end
            end

            ST_RESP: begin
               r_state       <= ST_IDLE;
               r_ld_done     <= 2'b00;
               r_ld_data     <= {WORD_W{1'b0}};
               r_ld_done_tag <= {TAG_W{1'b0}};
               r_st_ack      <= 1'b0;
            end

            default: begin
               r_state       <= ST_IDLE;
               r_ld_done     <= 2'b00;
               r_ld_data     <= {WORD_W{1'b0}};
               r_ld_done_tag <= {TAG_W{1'b0}};
               r_st_ack      <= 1'b0;
               r_mem_req     <= 1'b0;
               r_mem_we      <= 1'b0;
               r_mem_addr    <= {ADDR_W{1'b0}};
               r_mem_wdata   <= {WORD_W{1'b0}};
            end
         endcase
      end
   end

   // Outputs come straight from registers or from the state register.
   always_comb begin
      o_ld_done     = r_ld_done;
      o_ld_data     = r_ld_data;
      o_ld_done_tag = r_ld_done_tag;
      o_st_ack      = r_st_ack;
      o_mem_req     = r_mem_req;
      o_mem_we      = r_mem_we;
      o_mem_addr    = r_mem_addr;
      o_mem_wdata   = r_mem_wdata;
      o_busy        = (r_state != ST_IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  ld_req;
   logic [31:0] ld_addr0, ld_addr1, ld_tag0, ld_tag1;
   logic        st_req;
   logic [31:0] st_addr, st_data;
   logic [1:0]  ld_done;
   logic [31:0] ld_data, ld_done_tag;
   logic        st_ack, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Values captured by serve()
   logic [31:0] s_addr, s_wdata, s_tag, s_data;
   logic        s_we, s_ack;
   logic [1:0]  s_done;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_ld_req      (ld_req),
      .i_ld_addr0    (ld_addr0),
      .i_ld_addr1    (ld_addr1),
      .i_ld_tag0     (ld_tag0),
      .i_ld_tag1     (ld_tag1),
      .i_st_req      (st_req),
      .i_st_addr     (st_addr),
      .i_st_data     (st_data),
      .o_ld_done     (ld_done),
      .o_ld_data     (ld_data),
      .o_ld_done_tag (ld_done_tag),
      .o_st_ack      (st_ack),
      .o_mem_req     (mem_req),
      .o_mem_we      (mem_we),
      .o_mem_addr    (mem_addr),
      .o_mem_wdata   (mem_wdata),
      .i_mem_ready   (mem_ready),
      .i_mem_rdata   (mem_rdata),
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ld_req    = 2'b00;
      ld_addr0  = 32'h0;
      ld_addr1  = 32'h0;
      ld_tag0   = 32'h0;
      ld_tag1   = 32'h0;
      st_req    = 1'b0;
      st_addr   = 32'h0;
      st_data   = 32'h0;
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Wait (bounded) for a cache request, record it, complete it, record the pulse.
   task automatic serve(input logic [31:0] rdata);
      int n;
      n = 0;
      while (!mem_req && n < 20) begin
         tick();
         n++;
      end
      if (!mem_req) check("serve_timeout", 64'd0, 64'd1);
      s_addr    = mem_addr;
      s_we      = mem_we;
      s_wdata   = mem_wdata;
      mem_ready = 1'b1;
      mem_rdata = rdata;
      tick();
      s_done    = ld_done;
      s_ack     = st_ack;
      s_tag     = ld_done_tag;
      s_data    = ld_data;
      mem_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_addr [0:3];
      logic [1:0]  exp_done [0:3];
      rst = 1'b0;
      clear_inputs();
      #2;
      // Reset state
      check("rst_mem_req", {63'd0, mem_req}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_outs", {ld_done, st_ack, mem_we, mem_addr, ld_data[27:0]}, 64'd0);
      tick();
      rst = 1'b1;

      // Single load, minimum latency
      ld_req = 2'b01; ld_addr0 = 32'h40; ld_tag0 = 32'd7;
      mem_ready = 1'b1; mem_rdata = 32'hDEAD;
      tick();
      check("ld1_busy_req", {busy, mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 32'h40});
      tick();
      check("ld1_done", {ld_done, mem_req, ld_data}, {2'b01, 1'b0, 32'hDEAD});
      check("ld1_tag", ld_done_tag, 32'd7);
      ld_req = 2'b00; mem_ready = 1'b0;
      tick();
      check("ld1_pulse_end", {ld_done, busy}, {2'b00, 1'b0});

      // Round-robin between two held load ports
      do_reset();
      ld_req = 2'b11; ld_addr0 = 32'h100; ld_addr1 = 32'h200;
      ld_tag0 = 32'd1; ld_tag1 = 32'd2;
      exp_addr[0] = 32'h100; exp_addr[1] = 32'h200; exp_addr[2] = 32'h100; exp_addr[3] = 32'h200;
      exp_done[0] = 2'b01;   exp_done[1] = 2'b10;   exp_done[2] = 2'b01;   exp_done[3] = 2'b10;
      for (int i = 0; i < 4; i++) begin
         serve(32'hA000 + i);
         check("rr_addr", s_addr, exp_addr[i]);
         check("rr_done", {s_done, s_data}, {exp_done[i], 32'hA000 + i});
      end
      clear_inputs();
      tick(); tick();

      // Starvation: four loads, then the store, then the counter is clear again
      do_reset();
      st_req = 1'b1; st_addr = 32'h80; st_data = 32'h1234;
      ld_req = 2'b11; ld_addr0 = 32'h100; ld_addr1 = 32'h200;
      for (int i = 0; i < 4; i++) begin
         serve(32'h0);
         check("stv_load", {s_we, s_addr, s_done}, {1'b0, exp_addr[i], exp_done[i]});
      end
      serve(32'h0);
      check("stv_store", {s_we, s_addr, s_ack, s_done}, {1'b1, 32'h80, 1'b1, 2'b00});
      check("stv_wdata", s_wdata, 32'h1234);
      serve(32'h0);
      check("stv_cleared", {s_we, s_addr, s_done}, {1'b0, 32'h100, 2'b01});
      clear_inputs();
      tick(); tick();

      // Same-address load waits behind the store
      do_reset();
      st_req = 1'b1; st_addr = 32'h80; st_data = 32'h55;
      ld_req = 2'b01; ld_addr0 = 32'h80; ld_tag0 = 32'd4;
      serve(32'h0);
      check("ord_store_first", {s_we, s_addr, s_ack, s_done}, {1'b1, 32'h80, 1'b1, 2'b00});
      st_req = 1'b0;
      serve(32'h77);
      check("ord_load_after", {s_we, s_addr, s_done, s_data}, {1'b0, 32'h80, 2'b01, 32'h77});
      clear_inputs();
      tick(); tick();

      // Conflicting port 0 is skipped; port 1 load still beats the store
      do_reset();
      st_req = 1'b1; st_addr = 32'h80;
      ld_req = 2'b11; ld_addr0 = 32'h80; ld_addr1 = 32'h300;
      serve(32'h0);
      check("ord_other_port", {s_we, s_addr, s_done}, {1'b0, 32'h300, 2'b10});
      clear_inputs();
      tick(); tick();

      // Slow cache: five BUSY cycles with request dropped midway
      do_reset();
      ld_req = 2'b10; ld_addr1 = 32'h44; ld_tag1 = 32'd9;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("slow_hold", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h44});
         if (i == 2) ld_req = 2'b00;
         if (i < 4) tick();
      end
      mem_ready = 1'b1; mem_rdata = 32'hBEEF;
      tick();
      check("slow_done", {ld_done, mem_req, ld_data}, {2'b10, 1'b0, 32'hBEEF});
      check("slow_tag", ld_done_tag, 32'd9);
      mem_ready = 1'b0;
      tick();
      check("slow_pulse_end", {62'd0, ld_done}, 64'd0);

      // Reset during BUSY abandons the transaction
      do_reset();
      ld_req = 2'b01; ld_addr0 = 32'h40; ld_tag0 = 32'd3;
      tick();
      check("rstmid_req", {63'd0, mem_req}, 64'd1);
      #2 rst = 1'b0;
      #1;
      check("rstmid_async", {mem_req, busy}, {1'b0, 1'b0});
      @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      check("rstmid_reissue", {ld_done, mem_req, mem_addr}, {2'b00, 1'b1, 32'h40});
      mem_ready = 1'b1; mem_rdata = 32'h99;
      tick();
      check("rstmid_done", {ld_done, ld_data, ld_done_tag}, {2'b01, 32'h99, 32'd3});
      clear_inputs();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive load grants while a store waits.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low (asserted at 0).
REQ-004 ld_req  in  2  per-port load-miss request (port 0 and 1), level, held until done.
REQ-005 ld_addr0, ld_addr1  in  Address  load addresses, stable while ld_req high.
REQ-006 ld_tag0, ld_tag1  in  int  load tags, stable while ld_req high.
REQ-007 st_req  in  1  store-commit request, level, held until st_ack.
REQ-008 st_addr / st_data  in  Address / MemoryWord  store payload, stable while st_req high.
REQ-009 ld_done  out  2  one-hot, one-cycle pulse; load on that port completed.
REQ-010 ld_data  out  MemoryWord  load result, valid only while ld_done nonzero.
REQ-011 ld_done_tag  out  int  tag of completed load, valid with ld_done.
REQ-012 st_ack  out  1  one-cycle pulse; store written.
REQ-013 mem_req / mem_we  out  1 / 1  cache request, write enable.
REQ-014 mem_addr / mem_wdata  out  Address / MemoryWord  cache request payload.
REQ-015 mem_ready / mem_rdata  in  1 / MemoryWord  cache completion, read data valid with mem_ready.
REQ-016 busy  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states: IDLE, BUSY, RESP; exactly one active.
REQ-018 IDLE: if any eligible request, latch winner payload, port id and type; go to BUSY; else stay.
REQ-019 BUSY: mem_req=1 with latched addr/we/wdata; on mem_ready=1 capture mem_rdata, go to RESP; else stay, payload unchanged.
REQ-020 RESP: pulse the winner's ld_done bit (with ld_data, ld_done_tag) or st_ack for exactly one cycle; go to IDLE.
REQ-021 Requests are not sampled in BUSY or RESP; min latency from req in IDLE to done pulse = 2 cycles (mem_ready in first BUSY cycle).
REQ-022 Load priority: loads beat store unless starve count == STARVE_LIMIT, in which case the store wins.
REQ-023 Load-load tie: round-robin; the port not granted last wins; after reset port 0 has priority.
REQ-024 Ordering: a load whose address equals st_addr while st_req=1 is ineligible; if no other load is eligible the store wins.
REQ-025 Starve count (width clog2(STARVE_LIMIT+1)): +1 on each load grant while st_req=1; cleared on store grant or when IDLE sees st_req=0; saturates at STARVE_LIMIT.
REQ-026 mem_we=1 only for store transactions; mem_wdata is don't-care (drive 0) for loads.
REQ-027 Requester-protocol violation (req dropped before done) does not abort the transaction; completion still pulses.
REQ-028 All outputs are registered or decoded from state only; no combinational path from mem_ready to mem_req.

Reset
REQ-029 On reset=0: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_done=0, ld_data=0, ld_done_tag=0, st_ack=0, busy=0, starve count=0, round-robin pointer=port 0, immediately (asynchronous).
REQ-030 Reset mid-transaction abandons it: no done/ack pulse after release; requesters re-arbitrate from IDLE.

Structure
REQ-031 Address, MemoryWord and the state enum typedef live in the shared package; STARVE_LIMIT stays a module parameter.
REQ-032 Winner selection (REQ-022..024) is a combinational sub-module mem_port_pick; the FSM, latches and counters stay in mem_port_arbiter.

Verification
REQ-033 ld_req=01, addr0=0x40, tag0=7, mem_ready high in first BUSY cycle, rdata=0xDEAD -> mem_req for 1 cycle, ld_done=01 with ld_data=0xDEAD, tag 7, exactly 2 cycles after request.
REQ-034 ld_req=11 held, each completing -> grants alternate port 0, 1, 0, 1.
REQ-035 st_req=1 plus continuous loads at other addresses, STARVE_LIMIT=4 -> 4 load grants, then a store grant with mem_we=1, then the count clears.
REQ-036 st_req=1 with st_addr=0x80, only ld_req=01 with addr0=0x80 -> store granted first; the load is granted only after st_ack.
REQ-037 mem_ready held low 5 cycles -> mem_req and payload stable for all 5 BUSY cycles; done pulse follows the cycle after mem_ready.
REQ-038 reset=0 asserted during BUSY -> mem_req=0 immediately; no ld_done after release; the pending request is re-issued from IDLE.
